m1_reset_seq: RTL and testbench
===============================

// Module: m1_reset_seq
// PURPOSE
//  Reset sequencer between the rPLL and the Gowin EMPU M1 core. Synchronises PLL lock,
//  requires lock to be stable before releasing the CPU, holds hwRstn low for a minimum
//  time, and re-resets the CPU on lock loss, software request or sustained LOCKUP.
//  Runs on the 200 MHz PLL output; hwRstn_o drives the M1 hwRstn input.
// PARAMETERS
//  SYNC_STAGES      2     flops in pll_lock_i / LOCKUP_i / sw_rst_req_i synchronisers (>=2)
//  LOCK_STABLE_CYC  1024  consecutive synced-lock-high cycles before entering HOLD (>=1)
//  HOLD_CYC         64    cycles hwRstn_o stays low in HOLD (>=1)
//  LOCKUP_CYC       16    consecutive synced-LOCKUP-high cycles in RUN that trigger restart (>=1)
//  LOCKUP_RST_EN    1     1: LOCKUP restarts CPU; 0: LOCKUP ignored
// PORTS
//  HCLK_i        in   1  PLL clock (pll_clk_200_o)
//  hwRst_i       in   1  asynchronous reset, active-high
//  pll_lock_i    in   1  PLL lock, asynchronous to HCLK_i
//  LOCKUP_i      in   1  M1 LOCKUP output
//  sw_rst_req_i  in   1  software reset request, level; rising edge (after sync) acts
//  hwRstn_o      out  1  CPU reset, active-low, registered
//  rst_cause_o   out  2  last cause: 0 power/hwRst, 1 lock loss, 2 software, 3 lockup
//  rst_count_o   out  8  count of resets since hwRst_i, saturates at 255
//  run_o         out  1  high exactly while state==RUN
// BEHAVIOUR
//  - hwRst_i high (async): state=WAIT_LOCK, all sync flops 0, counters 0, hwRstn_o=0,
//    rst_cause_o=0, rst_count_o=0, run_o=0. Release is sampled on HCLK_i edges.
//  - lk = pll_lock_i after SYNC_STAGES flops; lu, sr likewise. sr_rise = sr & ~sr_d1.
//  - States (one-hot or binary, implementer's choice), hwRstn_o=1 only in RUN:
//    WAIT_LOCK: stab_cnt=0; lk=1 -> STABLE.
//    STABLE: stab_cnt++ each lk=1 cycle; lk=0 -> WAIT_LOCK (stab_cnt=0);
//      stab_cnt==LOCK_STABLE_CYC-1 with lk=1 -> HOLD, hold_cnt=0.
//    HOLD: hold_cnt++; lk=0 -> WAIT_LOCK; hold_cnt==HOLD_CYC-1 -> RUN.
//    RUN: lk=0 -> WAIT_LOCK, cause=1; else sr_rise -> HOLD, cause=2;
//      else lu held LOCKUP_CYC consecutive cycles and LOCKUP_RST_EN -> HOLD, cause=3.
//  - Priority on simultaneous events in RUN: lock loss > software > lockup.
//  - lu_cnt counts in RUN only, clears on lu=0 or state exit; saturates, no wrap.
//  - sw_rst_req_i / LOCKUP_i outside RUN are ignored (no cause update, no count).
//  - hwRstn_o, run_o registered from next-state: deassert in the cycle the FSM enters RUN,
//    assert (0) in the cycle it leaves RUN. Latency lock-edge->hwRstn_o=1 is
//    SYNC_STAGES+LOCK_STABLE_CYC+HOLD_CYC cycles (+-1 for async sampling).
//  - rst_count_o increments by 1 on every RUN exit; holds at 255. rst_cause_o updates
//    on same edge; holds until next RUN exit or hwRst_i.
//  - Counter widths = $clog2(param)+1; no counter ever wraps.
//  - Lock glitch shorter than SYNC_STAGES cycles may be missed; a glitch seen by lk
//    restarts the stability window from zero.
// TESTING (LOCK_STABLE_CYC=8, HOLD_CYC=4, LOCKUP_CYC=3, SYNC_STAGES=2)
//  1 hwRst_i pulse, pll_lock_i=1 steady -> hwRstn_o=0 until 14 cycles after release (+-1),
//    then 1; run_o=1; rst_count_o=0, rst_cause_o=0.
//  2 In RUN drop pll_lock_i 5 cycles -> hwRstn_o=0 within 3 cycles; cause=1, count=1;
//    relock -> hwRstn_o=1 after 14 more cycles.
//  3 Lock toggles low for 3 cycles during STABLE at cnt 6 -> window restarts; full 8+4 needed.
//  4 In RUN pulse sw_rst_req_i 1 cycle (held 3) -> hwRstn_o low exactly 4 cycles; cause=2.
//  5 LOCKUP_i high 2 cycles -> no reset; high 3 cycles -> reset, cause=3; LOCKUP_RST_EN=0 -> none.
//  6 Lock loss + sw request same cycle -> cause=1; force 260 resets -> rst_count_o=255;
//    assert hwRst_i mid-HOLD -> all outputs reset values immediately.

Source files
------------

// File: rtl/m1_reset_seq_if.sv
// m1_reset_seq_if
// Groups the CPU-side signals of the rPLL -> EMPU M1 reset sequencer.
//   pll_lock_i    PLL lock, asynchronous to the sequencer clock
//   LOCKUP_i      M1 LOCKUP output
//   sw_rst_req_i  software reset request (level; the synchronised rising edge acts)
//   hwRstn_o      active-low CPU reset, registered
//   rst_cause_o   last reset cause: 0 power/hwRst, 1 lock loss, 2 software, 3 lockup
//   rst_count_o   resets since hwRst, saturating at 255
//   run_o         high while the sequencer is in RUN
// slave: the sequencer side. master: the surrounding system side.
interface m1_reset_seq_if;
    logic       pll_lock_i;
    logic       LOCKUP_i;
    logic       sw_rst_req_i;
    logic       hwRstn_o;
    logic [1:0] rst_cause_o;
    logic [7:0] rst_count_o;
    logic       run_o;

    modport slave (
        input  pll_lock_i, LOCKUP_i, sw_rst_req_i,
        output hwRstn_o, rst_cause_o, rst_count_o, run_o
    );

    modport master (
        output pll_lock_i, LOCKUP_i, sw_rst_req_i,
        input  hwRstn_o, rst_cause_o, rst_count_o, run_o
    );
endinterface

// File: rtl/m1_reset_seq.sv
// m1_reset_seq
// Reset sequencer between the rPLL and the EMPU M1 core. Synchronises PLL lock,
// waits for a stable lock window, holds the CPU in reset for a minimum time and
// re-resets it on lock loss, software request or sustained LOCKUP.
// Ports:
//   HCLK_i   PLL output clock (200 MHz)
//   hwRst_i  asynchronous reset, active-high
//   bus      m1_reset_seq_if.slave (lock/LOCKUP/sw request in, CPU reset and status out)
//
// state     | meaning
// WAIT_LOCK | synced lock low, CPU held in reset
// STABLE    | lock high, counting the stability window
// HOLD      | lock stable, holding CPU reset for the minimum time
// RUN       | CPU released; watching for lock loss, sw request, LOCKUP
module m1_reset_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int HOLD_CYC        = 64,
    parameter int LOCKUP_CYC      = 16,
    parameter bit LOCKUP_RST_EN   = 1'b1
) (
    input  logic            HCLK_i,
    input  logic            hwRst_i,
    m1_reset_seq_if.slave   bus
);

    localparam int SW = $clog2(LOCK_STABLE_CYC) + 1;
    localparam int HW = $clog2(HOLD_CYC) + 1;
    localparam int LW = $clog2(LOCKUP_CYC) + 1;

    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [LW-1:0] LU_LAST   = LW'(LOCKUP_CYC - 1);
    localparam logic [LW-1:0] LU_MAX    = LW'(LOCKUP_CYC);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lk_sync;
    logic [SYNC_STAGES-1:0] lu_sync;
    logic [SYNC_STAGES-1:0] sr_sync;
    logic                   sr_d1;
    logic [SW-1:0]          stab_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [LW-1:0]          lu_cnt;
    logic                   hwrstn_q;
    logic                   run_q;
    logic [1:0]             cause_q;
    logic [7:0]             count_q;

    logic lk, lu, sr, sr_rise;

    assign lk      = lk_sync[SYNC_STAGES-1];
    assign lu      = lu_sync[SYNC_STAGES-1];
    assign sr      = sr_sync[SYNC_STAGES-1];
    assign sr_rise = sr & ~sr_d1;

    assign bus.hwRstn_o    = hwrstn_q;
    assign bus.run_o       = run_q;
    assign bus.rst_cause_o = cause_q;
    assign bus.rst_count_o = count_q;

    always_ff @(posedge HCLK_i or posedge hwRst_i) begin
        if (hwRst_i) begin
            state    <= WAIT_LOCK;
            lk_sync  <= '0;
            lu_sync  <= '0;
            sr_sync  <= '0;
            sr_d1    <= 1'b0;
            stab_cnt <= '0;
            hold_cnt <= '0;
            lu_cnt   <= '0;
            hwrstn_q <= 1'b0;
            run_q    <= 1'b0;
            cause_q  <= 2'd0;
            count_q  <= 8'd0;
        end else begin
            lk_sync <= {lk_sync[SYNC_STAGES-2:0], bus.pll_lock_i};
            lu_sync <= {lu_sync[SYNC_STAGES-2:0], bus.LOCKUP_i};
            sr_sync <= {sr_sync[SYNC_STAGES-2:0], bus.sw_rst_req_i};
            sr_d1   <= sr;

            case (state)
                WAIT_LOCK: begin
                    stab_cnt <= '0;
                    hold_cnt <= '0;
                    lu_cnt   <= '0;
                    if (lk) state <= STABLE;
                end
                STABLE: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= RUN;
                        hwrstn_q <= 1'b1;
                        run_q    <= 1'b1;
                        lu_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Any exit: drop reset in the same edge, log cause, bump count.
                    if (!lk || sr_rise || (LOCKUP_RST_EN && lu && lu_cnt >= LU_LAST)) begin
                        hwrstn_q <= 1'b0;
                        run_q    <= 1'b0;
                        lu_cnt   <= '0;
                        hold_cnt <= '0;
                        stab_cnt <= '0;
                        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                        if (!lk) begin
                            state   <= WAIT_LOCK;
                            cause_q <= 2'd1;
                        end else if (sr_rise) begin
                            state   <= HOLD;
                            cause_q <= 2'd2;
                        end else begin
                            state   <= HOLD;
                            cause_q <= 2'd3;
                        end
                    end else if (!lu) begin
                        lu_cnt <= '0;
                    end else if (lu_cnt != LU_MAX) begin
                        lu_cnt <= lu_cnt + 1'b1;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_m1_reset_seq.sv
module tb_m1_reset_seq;

    localparam int N = 8;
    localparam int H = 4;
    localparam int L = 3;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock = 1'b1;
    logic lu_in = 1'b0;
    logic sw = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m1_reset_seq_if ifa ();
    m1_reset_seq_if ifb ();

    assign ifa.pll_lock_i   = lock;
    assign ifa.LOCKUP_i     = lu_in;
    assign ifa.sw_rst_req_i = sw;
    assign ifb.pll_lock_i   = lock;
    assign ifb.LOCKUP_i     = lu_in;
    assign ifb.sw_rst_req_i = sw;

    m1_reset_seq #(.SYNC_STAGES(S), .LOCK_STABLE_CYC(N), .HOLD_CYC(H),
                   .LOCKUP_CYC(L), .LOCKUP_RST_EN(1'b1))
        dut_a (.HCLK_i(clk), .hwRst_i(rst), .bus(ifa));

    m1_reset_seq #(.SYNC_STAGES(S), .LOCK_STABLE_CYC(N), .HOLD_CYC(H),
                   .LOCKUP_CYC(L), .LOCKUP_RST_EN(1'b0))
        dut_b (.HCLK_i(clk), .hwRst_i(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: CPU runs once synced lock has been seen high for
    // N+H+1 consecutive edges from a lock-lost start, or H edges after a
    // software/lockup restart. Inputs are seen through an S-edge delay.
    typedef struct packed {
        logic       run;
        int         streak;
        int         hold_rem;
        int         lu_streak;
        logic [1:0] cause;
        int         count;
    } mdl_t;

    function automatic mdl_t leave_run(input mdl_t m, input logic [1:0] c, input int hold);
        mdl_t r = m;
        r.run       = 1'b0;
        r.cause     = c;
        r.count     = (m.count < 255) ? m.count + 1 : 255;
        r.hold_rem  = hold;
        r.streak    = 0;
        r.lu_streak = 0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic lk, input logic lu,
                                  input logic srr, input logic en);
        mdl_t r = m;
        if (!lk) begin
            if (m.run) r = leave_run(m, 2'd1, 0);
            r.streak   = 0;
            r.hold_rem = 0;
        end else if (m.run) begin
            r.lu_streak = lu ? m.lu_streak + 1 : 0;
            if (srr)                         r = leave_run(m, 2'd2, H);
            else if (en && r.lu_streak >= L) r = leave_run(m, 2'd3, H);
        end else if (m.hold_rem > 0) begin
            r.hold_rem = m.hold_rem - 1;
            if (r.hold_rem == 0) r.run = 1'b1;
        end else begin
            r.streak = m.streak + 1;
            if (r.streak == N + H + 1) begin
                r.run    = 1'b1;
                r.streak = 0;
            end
        end
        return r;
    endfunction

    mdl_t         ma, mb;
    logic [S-1:0] lk_p, lu_p, sr_p;
    logic         sr_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma      <= '0;
            mb      <= '0;
            lk_p    <= '0;
            lu_p    <= '0;
            sr_p    <= '0;
            sr_prev <= 1'b0;
        end else begin
            ma      <= step(ma, lk_p[S-1], lu_p[S-1], sr_p[S-1] & ~sr_prev, 1'b1);
            mb      <= step(mb, lk_p[S-1], lu_p[S-1], sr_p[S-1] & ~sr_prev, 1'b0);
            sr_prev <= sr_p[S-1];
            lk_p    <= {lk_p[S-2:0], lock};
            lu_p    <= {lu_p[S-2:0], lu_in};
            sr_p    <= {sr_p[S-2:0], sw};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_hwrstn", ifa.hwRstn_o,    ma.run);
            chk("a_run",    ifa.run_o,       ma.run);
            chk("a_cause",  ifa.rst_cause_o, ma.cause);
            chk("a_count",  ifa.rst_count_o, ma.count);
            chk("b_hwrstn", ifb.hwRstn_o,    mb.run);
            chk("b_run",    ifb.run_o,       mb.run);
            chk("b_cause",  ifb.rst_cause_o, mb.cause);
            chk("b_count",  ifb.rst_count_o, mb.count);
        end
    end

    // Wait (bounded) for dut_a run_o to reach lvl; n = edges waited.
    task automatic wait_run(input string tag, input logic lvl, input int max, output int n);
        n = 0;
        while (ifa.run_o !== lvl && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, ifa.run_o, lvl);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hwrstn"}, ifa.hwRstn_o, 0);
        chk({tag, "_run"},    ifa.run_o, 0);
        chk({tag, "_cause"},  ifa.rst_cause_o, 0);
        chk({tag, "_count"},  ifa.rst_count_o, 0);
    endtask

    initial begin
        int n;
        int low_left;
        int lu_left;

        repeat (3) @(negedge clk);
        chk_reset_vals("por");

        // 1: release with steady lock
        @(negedge clk); #1 rst = 1'b0;
        wait_run("t1_wait", 1'b1, 100, n);
        chk("t1_latency_ok", (n >= 13 && n <= 16), 1);
        chk("t1_count", ifa.rst_count_o, 0);
        chk("t1_cause", ifa.rst_cause_o, 0);

        // 2: lock loss in RUN
        repeat (5) @(negedge clk);
        lock = 1'b0;
        wait_run("t2_drop", 1'b0, 20, n);
        chk("t2_drop_within3", (n <= 3), 1);
        repeat (2) @(negedge clk);
        chk("t2_cause", ifa.rst_cause_o, 1);
        chk("t2_count", ifa.rst_count_o, 1);
        lock = 1'b1;
        wait_run("t2_relock", 1'b1, 100, n);
        chk("t2_relock_latency_ok", (n >= 13 && n <= 16), 1);

        // 3: glitch during STABLE at count 6 restarts the window
        @(negedge clk); lock = 1'b0;
        repeat (5) @(negedge clk);
        lock = 1'b1;
        repeat (7) @(negedge clk);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        lock = 1'b1;
        wait_run("t3_wait", 1'b1, 100, n);
        chk("t3_full_window", (n >= 14 && n <= 16), 1);

        // 4: software request; only the rising edge acts
        repeat (4) @(negedge clk);
        sw = 1'b1;
        wait_run("t4_drop", 1'b0, 20, n);
        wait_run("t4_back", 1'b1, 20, n);
        chk("t4_low_cycles", n, H);
        chk("t4_cause", ifa.rst_cause_o, 2);
        repeat (6) @(negedge clk);
        chk("t4_level_no_rerun", ifa.run_o, 1);
        sw = 1'b0;
        repeat (3) @(negedge clk);

        // 5: LOCKUP 2 cycles ignored, 3 cycles restarts (only when enabled)
        lu_in = 1'b1;
        repeat (2) @(negedge clk);
        lu_in = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_lu2_run", ifa.run_o, 1);
        chk("t5_lu2_cause", ifa.rst_cause_o, 2);
        lu_in = 1'b1;
        repeat (3) @(negedge clk);
        lu_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_lu3_cause", ifa.rst_cause_o, 3);
        chk("t5_dis_run", ifb.run_o, 1);
        chk("t5_dis_cause", ifb.rst_cause_o, 2);
        wait_run("t5_back", 1'b1, 20, n);

        // 6: lock loss and sw request together -> lock loss wins
        repeat (3) @(negedge clk);
        lock = 1'b0;
        sw   = 1'b1;
        wait_run("t6_drop", 1'b0, 20, n);
        repeat (2) @(negedge clk);
        chk("t6_prio_cause", ifa.rst_cause_o, 1);
        sw   = 1'b0;
        lock = 1'b1;
        wait_run("t6_relock", 1'b1, 100, n);

        // count saturation
        for (int i = 0; i < 260; i++) begin
            @(negedge clk); sw = 1'b1;
            @(negedge clk); sw = 1'b0;
            wait_run("sat_drop", 1'b0, 20, n);
            wait_run("sat_back", 1'b1, 20, n);
        end
        chk("sat_count", ifa.rst_count_o, 255);
        chk("sat_count_b", ifb.rst_count_o, 255);

        // hwRst mid-HOLD clears outputs at once
        @(negedge clk); sw = 1'b1;
        @(negedge clk); sw = 1'b0;
        wait_run("hold_enter", 1'b0, 20, n);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midhold");
        chk("midhold_b_count", ifb.rst_count_o, 0);

        // randomized traffic against the model
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        low_left = 0;
        lu_left  = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (low_left > 0) begin
                low_left--;
                lock = 1'b0;
            end else begin
                lock = 1'b1;
                if ($urandom_range(0, 79) == 0) low_left = $urandom_range(1, 8);
            end
            if (lu_left > 0) begin
                lu_left--;
                lu_in = 1'b1;
            end else begin
                lu_in = 1'b0;
                if ($urandom_range(0, 24) == 0) lu_left = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 29) == 0) sw = ~sw;
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
